// File: rtl/mealy_share_arb_pkg.sv
// Shared constants and types for the two-source Mealy detector sharing arbiter.
package mealy_share_arb_pkg;

    localparam int SYM_W = 2;
    localparam logic [SYM_W-1:0] SYM_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/mealy_share_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step only while below the saturation value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register; clear has priority so an increment in the clear cycle is dropped.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mealy_share_arb.sv
// Round-robin arbiter that time-shares one Mealy sequence detector between two
// symbol sources, holding the detector in reset between bursts and crediting
// each detection to the source whose symbol produced it.
module mealy_share_arb
    import mealy_share_arb_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_sym,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_sym,
    output logic             req1_ready,
    output logic [1:0]       det_a,
    output logic             det_reset,
    input  logic             det_out,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] hit0_cnt,
    output logic [CNT_W-1:0] hit1_cnt
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    state_e             state_q,     state_d;
    logic [1:0]         grant_q,     grant_d;
    logic [BEAT_W-1:0]  beats_q,     beats_d;
    logic               sym_live_q,  sym_live_d;
    logic               last_q,      last_d;      // 1: source 1 owned the previous burst
    logic [SYM_W-1:0]   det_a_q,     det_a_d;
    logic               det_reset_q, det_reset_d;
    logic               busy_q,      busy_d;

    logic               in_burst;
    logic               beat_room;
    logic               accept;
    logic [SYM_W-1:0]   owner_sym;
    logic [BEAT_W-1:0]  beats_inc;
    logic               hit0_inc;
    logic               hit1_inc;

    // Ready is decoded purely from registers so it never depends on valid.
    assign in_burst   = (state_q == ST_BURST);
    assign beat_room  = (beats_q < BEAT_MAX);
    assign req0_ready = in_burst & grant_q[0] & beat_room;
    assign req1_ready = in_burst & grant_q[1] & beat_room;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign owner_sym  = grant_q[1] ? req1_sym : req0_sym;
    assign beats_inc  = beats_q + BEAT_ONE;

    // Next-state logic for the arbiter FSM, beat counter and detector drive.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beats_d     = beats_q;
        last_d      = last_q;
        sym_live_d  = 1'b0;
        det_a_d     = SYM_IDLE;
        det_reset_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        grant_d = last_q ? 2'b01 : 2'b10;
                    end else if (req1_valid) begin
                        grant_d = 2'b10;
                    end else begin
                        grant_d = 2'b01;
                    end
                    beats_d = '0;
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                det_reset_d = 1'b0;
                if (accept) begin
                    det_a_d    = owner_sym;
                    sym_live_d = 1'b1;
                    beats_d    = beats_inc;
                    if (beats_inc == BEAT_MAX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    // A gap ends the burst: bursts never contain idle beats.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Owner stays visible through DRAIN so the last symbol is credited.
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            beats_q     <= '0;
            sym_live_q  <= 1'b0;
            last_q      <= 1'b1;
            det_a_q     <= SYM_IDLE;
            det_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beats_q     <= beats_d;
            sym_live_q  <= sym_live_d;
            last_q      <= last_d;
            det_a_q     <= det_a_d;
            det_reset_q <= det_reset_d;
            busy_q      <= busy_d;
        end
    end

    assign det_a     = det_a_q;
    assign det_reset = det_reset_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

    // A detection counts only while a real symbol sits on det_a.
    assign hit0_inc = sym_live_q & det_out & grant_q[0];
    assign hit1_inc = sym_live_q & det_out & grant_q[1];

    sat_counter #(.CNT_W(CNT_W)) u_hit0 (
        .clk   (clk),
        .clear (reset),
        .inc   (hit0_inc),
        .cnt   (hit0_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hit1 (
        .clk   (clk),
        .clear (reset),
        .inc   (hit1_inc),
        .cnt   (hit1_cnt)
    );

endmodule

// File: tb/tb_mealy_share_arb.sv
// Directed bench for mealy_share_arb: instance a (BURST_LEN=8, CNT_W=8) and
// instance b (BURST_LEN=3, CNT_W=2), each with a bench detector that fires
// when det_a equals a selectable match symbol.
module tb_mealy_share_arb;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       a_v0, a_v1, a_r0, a_r1, a_det_reset, a_det_out, a_busy;
    logic [1:0] a_s0, a_s1, a_det_a, a_grant, a_match;
    logic [7:0] a_hit0, a_hit1;

    logic       b_v0, b_v1, b_r0, b_r1, b_det_reset, b_det_out, b_busy;
    logic [1:0] b_s0, b_s1, b_det_a, b_grant, b_match;
    logic [1:0] b_hit0, b_hit1;

    int         runs [8];
    int         n_runs;
    int         n_grants;
    int         other_ready;
    logic [1:0] eg;
    logic [1:0] syms [4];

    assign a_det_out = (a_det_a == a_match);
    assign b_det_out = (b_det_a == b_match);

    always #5 clk = ~clk;

    mealy_share_arb u_a (
        .clk(clk), .reset(reset),
        .req0_valid(a_v0), .req0_sym(a_s0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_sym(a_s1), .req1_ready(a_r1),
        .det_a(a_det_a), .det_reset(a_det_reset), .det_out(a_det_out),
        .grant(a_grant), .busy(a_busy), .hit0_cnt(a_hit0), .hit1_cnt(a_hit1)
    );

    mealy_share_arb #(.BURST_LEN(3), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_v0), .req0_sym(b_s0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_sym(b_s1), .req1_ready(b_r1),
        .det_a(b_det_a), .det_reset(b_det_reset), .det_out(b_det_out),
        .grant(b_grant), .busy(b_busy), .hit0_cnt(b_hit0), .hit1_cnt(b_hit1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one source of instance b for n accepted symbols, record ready runs
    // and grant count, then wait for the arbiter to return to IDLE.
    task automatic run_b(input int src, input int n, input logic [1:0] sym);
        int   accepted;
        int   run;
        logic prev_g;
        logic rdy;
        logic val;
        logic done;
        accepted = 0; run = 0; prev_g = 1'b0; done = 1'b0;
        n_runs = 0; n_grants = 0; other_ready = 0;
        if (src == 0) begin b_v0 = 1'b1; b_s0 = sym; end
        else          begin b_v1 = 1'b1; b_s1 = sym; end
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            rdy = (src == 0) ? b_r0 : b_r1;
            val = (src == 0) ? b_v0 : b_v1;
            if ((src == 0) ? b_r1 : b_r0) other_ready++;
            if (b_grant[src] && !prev_g) n_grants++;
            prev_g = b_grant[src];
            if (val && rdy) begin
                accepted++;
                run++;
            end else if (run != 0) begin
                if (n_runs < 8) runs[n_runs] = run;
                n_runs++;
                run = 0;
            end
            tick();
            if (accepted == n) begin b_v0 = 1'b0; b_v1 = 1'b0; end
            if (accepted == n && !b_busy) done = 1'b1;
        end
        if (run != 0) begin
            if (n_runs < 8) runs[n_runs] = run;
            n_runs++;
        end
        chk_eq("b_run_done", done, 1'b1);
        chk_eq("b_other_ready", other_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_v0 = 1'b0; a_v1 = 1'b0; a_s0 = 2'b00; a_s1 = 2'b00; a_match = 2'b01;
        b_v0 = 1'b0; b_v1 = 1'b0; b_s0 = 2'b00; b_s1 = 2'b00; b_match = 2'b11;
        syms[0] = 2'b10; syms[1] = 2'b01; syms[2] = 2'b00; syms[3] = 2'b01;
        tick();
        tick();
        // Reset state
        chk_eq("rst_det_a", a_det_a, 2'b00);
        chk_eq("rst_det_reset", a_det_reset, 1'b1);
        chk_eq("rst_grant", a_grant, 2'b00);
        chk_eq("rst_busy", a_busy, 1'b0);
        chk_eq("rst_ready", {a_r0, a_r1}, 2'b00);
        chk_eq("rst_hits", {a_hit0, a_hit1}, 16'h0000);
        reset = 1'b0;

        // Single source burst of 4 symbols
        a_v0 = 1'b1; a_s0 = syms[0];
        tick();
        chk_eq("single_grant", a_grant, 2'b01);
        chk_eq("single_busy", a_busy, 1'b1);
        chk_eq("single_first_det_reset", a_det_reset, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a_s0 = syms[i];
            chk_eq("single_ready0", a_r0, 1'b1);
            chk_eq("single_ready1", a_r1, 1'b0);
            tick();
            chk_eq("single_det_a", a_det_a, syms[i]);
            chk_eq("single_det_reset", a_det_reset, 1'b0);
        end
        a_v0 = 1'b0;
        tick();
        chk_eq("single_drain_busy", a_busy, 1'b1);
        chk_eq("single_drain_grant", a_grant, 2'b01);
        chk_eq("single_drain_det_a", a_det_a, 2'b00);
        chk_eq("single_hit0", a_hit0, 8'd2);
        tick();
        chk_eq("single_idle_grant", a_grant, 2'b00);
        chk_eq("single_idle_busy", a_busy, 1'b0);
        chk_eq("single_idle_det_reset", a_det_reset, 1'b1);
        chk_eq("single_hit1", a_hit1, 8'd0);

        // det_out high while no symbol is live must be ignored
        a_match = 2'b00;
        tick();
        tick();
        chk_eq("idle_det_out_ignored", a_hit0, 8'd2);

        // Contention: both valid, grants alternate starting with source 1
        a_match = 2'b11; a_s0 = 2'b10; a_s1 = 2'b10; a_v0 = 1'b1; a_v1 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            eg = (b % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            chk_eq("cont_grant", a_grant, eg);
            for (int i = 0; i < 8; i++) begin
                chk_eq("cont_owner_ready", eg[0] ? a_r0 : a_r1, 1'b1);
                chk_eq("cont_other_ready", eg[0] ? a_r1 : a_r0, 1'b0);
                tick();
            end
            chk_eq("cont_drain_busy", a_busy, 1'b1);
            chk_eq("cont_drain_ready", a_r0 | a_r1, 1'b0);
            tick();
            chk_eq("cont_idle_grant", a_grant, 2'b00);
            chk_eq("cont_idle_det_reset", a_det_reset, 1'b1);
            chk_eq("cont_idle_busy", a_busy, 1'b0);
        end
        a_v0 = 1'b0; a_v1 = 1'b0;
        chk_eq("cont_hits", {a_hit0, a_hit1}, {8'd2, 8'd0});

        // Last-symbol credit: only the 8th symbol of a source 0 burst hits
        a_v0 = 1'b1; a_s0 = 2'b10;
        tick();
        chk_eq("last_grant0", a_grant, 2'b01);
        for (int i = 0; i < 8; i++) begin
            a_s0 = (i == 7) ? 2'b11 : 2'b10;
            tick();
        end
        chk_eq("last_drain_det_a", a_det_a, 2'b11);
        chk_eq("last_before_credit", a_hit0, 8'd2);
        a_v0 = 1'b0; a_v1 = 1'b1; a_s1 = 2'b10;
        tick();
        chk_eq("last_hit0", a_hit0, 8'd3);
        chk_eq("last_idle_grant", a_grant, 2'b00);
        tick();
        chk_eq("last_grant1", a_grant, 2'b10);
        chk_eq("last_hit1_granted", a_hit1, 8'd0);
        tick();
        a_v1 = 1'b0;
        tick();
        tick();
        chk_eq("last_hit1_after", a_hit1, 8'd0);
        chk_eq("last_hit0_after", a_hit0, 8'd3);

        // Burst cap on instance b (BURST_LEN=3): 10 symbols from source 1
        run_b(1, 10, 2'b10);
        chk_eq("cap_grants", n_grants, 4);
        chk_eq("cap_runs", n_runs, 4);
        chk_eq("cap_run0", runs[0], 3);
        chk_eq("cap_run1", runs[1], 3);
        chk_eq("cap_run2", runs[2], 3);
        chk_eq("cap_run3", runs[3], 1);
        chk_eq("cap_hits", {b_hit0, b_hit1}, 4'h0);

        // Saturation on instance b (CNT_W=2): 5 detections for source 0
        b_match = 2'b01;
        run_b(0, 5, 2'b01);
        chk_eq("sat_grants", n_grants, 2);
        chk_eq("sat_hit0", b_hit0, 2'd3);
        chk_eq("sat_hit1", b_hit1, 2'd0);

        // Reset mid-burst on instance a with a detection pending
        a_match = 2'b01; a_s0 = 2'b01; a_v0 = 1'b1;
        tick();
        tick();
        tick();
        chk_eq("mid_hit0_before", a_hit0, 8'd4);
        chk_eq("mid_pending_det_out", a_det_out, 1'b1);
        reset = 1'b1; a_v0 = 1'b0;
        tick();
        reset = 1'b0;
        chk_eq("mid_det_a", a_det_a, 2'b00);
        chk_eq("mid_det_reset", a_det_reset, 1'b1);
        chk_eq("mid_grant", a_grant, 2'b00);
        chk_eq("mid_busy", a_busy, 1'b0);
        chk_eq("mid_hits", {a_hit0, a_hit1}, 16'h0000);
        tick();
        chk_eq("mid_hits_after", {a_hit0, a_hit1}, 16'h0000);
        chk_eq("mid_b_hits", {b_hit0, b_hit1}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
